// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer state encoding and the
// register numbers the decode stage already uses for $k0 and $ra.
package cpu_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_SERVICE  = 2'd1,
        IRQ_COOLDOWN = 2'd2
    } irq_state_e;

    localparam logic [4:0] REG_K0 = 5'd26;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/irq_sync.sv
// Brings the asynchronous interrupt level into the clk domain and turns
// each rising level into a single-cycle irq_edge pulse.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_irq,
    output logic irq_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: latches synchronised edges, injects IRQ into
// ID only in a safe slot, and blocks re-entry until eret plus a cool-down.
module irq_sequencer
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_GAP     = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_irq,
    input  logic             irq_enable,
    input  logic             id_valid,
    input  logic             supervise,
    input  logic             data_hazard,
    input  logic             branch_hazard,
    input  logic             jump_hazard,
    input  logic             exception,
    input  logic             eret,
    output logic             IRQ,
    output logic             irq_pending,
    output logic             irq_busy,
    output logic [CNT_W-1:0] irq_count
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    irq_state_e       state_q, state_d;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             irq_edge;
    logic             ok;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ext_irq  (ext_irq),
        .irq_edge (irq_edge)
    );

    assign ok = id_valid & ~supervise & ~data_hazard & ~branch_hazard
              & ~jump_hazard & ~exception;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gap_d   = gap_q;
        IRQ     = 1'b0;
        unique case (state_q)
            IRQ_IDLE: begin
                IRQ = pending_q & ok;
                if (IRQ) begin
                    state_d = IRQ_SERVICE;
                    count_d = count_q + CNT_W'(1);
                end
            end
            IRQ_SERVICE: begin
                if (eret) begin
                    gap_d   = GAP_W'(MIN_GAP - 1);
                    state_d = IRQ_COOLDOWN;
                end
            end
            IRQ_COOLDOWN: begin
                if (gap_q == '0) state_d = IRQ_IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = IRQ_IDLE;
        endcase

        // A new edge outranks the clear from a same-cycle injection.
        if (!irq_enable)   pending_d = 1'b0;
        else if (irq_edge) pending_d = 1'b1;
        else if (IRQ)      pending_d = 1'b0;
        else               pending_d = pending_q;

        busy_d = (state_d != IRQ_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IRQ_IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq_busy    = busy_q;
    assign irq_count   = count_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry, blocked slots, nesting/cool-down,
// level/enable handling, set-vs-clear collision and reset during service.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_irq, irq_enable, id_valid, supervise;
    logic        data_hazard, branch_hazard, jump_hazard, exception, eret;
    logic        IRQ, irq_pending, irq_busy;
    logic [15:0] irq_count;

    int total = 0;
    int bad   = 0;

    irq_sequencer #(.SYNC_STAGES(2), .MIN_GAP(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_irq       (ext_irq),
        .irq_enable    (irq_enable),
        .id_valid      (id_valid),
        .supervise     (supervise),
        .data_hazard   (data_hazard),
        .branch_hazard (branch_hazard),
        .jump_hazard   (jump_hazard),
        .exception     (exception),
        .eret          (eret),
        .IRQ           (IRQ),
        .irq_pending   (irq_pending),
        .irq_busy      (irq_busy),
        .irq_count     (irq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop the line long enough to clear the synchroniser, then raise it.
    task automatic irq_rise();
        ext_irq = 1'b0;
        repeat (3) tick();
        ext_irq = 1'b1;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ext_irq = 1'b0; irq_enable = 1'b0; id_valid = 1'b1;
        supervise = 1'b0; data_hazard = 1'b0; branch_hazard = 1'b0;
        jump_hazard = 1'b0; exception = 1'b0; eret = 1'b0;
        #1;
        check("rst_irq", IRQ, 0);
        check("rst_pending", irq_pending, 0);
        check("rst_busy", irq_busy, 0);
        check("rst_count", irq_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        irq_enable = 1'b1;
        tick();

        // Basic entry: line sampled high at edge k.
        ext_irq = 1'b1;
        tick();                                   // k
        check("entry_pend_k", irq_pending, 0);
        tick();                                   // k+1
        check("entry_pend_k1", irq_pending, 0);
        check("entry_irq_k1", IRQ, 0);
        tick();                                   // k+2
        check("entry_pend_k2", irq_pending, 1);
        check("entry_irq", IRQ, 1);
        check("entry_busy_pre", irq_busy, 0);
        tick();
        check("entry_irq_once", IRQ, 0);
        check("entry_count", irq_count, 1);
        check("entry_busy", irq_busy, 1);
        check("entry_pend_clr", irq_pending, 0);

        // Held level: one event only.
        repeat (50) tick();
        check("level_pend", irq_pending, 0);
        do_eret();                                // e
        check("cool_busy_e", irq_busy, 1);
        repeat (3) tick();                        // e+3
        check("cool_busy_e3", irq_busy, 1);
        tick();                                   // e+4
        check("cool_busy_e4", irq_busy, 0);
        check("level_no_irq", IRQ, 0);
        check("level_count", irq_count, 1);

        // Blocked slot: data hazard x3, branch hazard x1, then ok.
        data_hazard = 1'b1;
        irq_rise();
        repeat (3) tick();
        check("blk_pend", irq_pending, 1);
        check("blk_dh1", IRQ, 0);
        tick();
        check("blk_dh2", IRQ, 0);
        tick();
        check("blk_dh3", IRQ, 0);
        check("blk_pend_hold", irq_pending, 1);
        data_hazard = 1'b0; branch_hazard = 1'b1;
        tick();
        check("blk_br", IRQ, 0);
        branch_hazard = 1'b0;
        #1;
        check("blk_ok_irq", IRQ, 1);
        tick();
        check("blk_irq_once", IRQ, 0);
        check("blk_count", irq_count, 2);

        // Nesting: edge during SERVICE stays pending until cool-down ends.
        irq_rise();
        repeat (3) tick();
        check("nest_pend", irq_pending, 1);
        check("nest_no_irq", IRQ, 0);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        check("nest_exc_busy", irq_busy, 1);
        do_eret();                                // e
        check("nest_e0", IRQ, 0);
        tick();
        check("nest_e1", IRQ, 0);
        tick();
        check("nest_e2", IRQ, 0);
        tick();
        check("nest_e3", IRQ, 0);
        tick();                                   // e+4
        check("nest_e4_irq", IRQ, 1);
        check("nest_e4_busy", irq_busy, 0);
        tick();
        check("nest_count", irq_count, 3);
        check("nest_busy", irq_busy, 1);

        // Supervisor hold-off, then an edge coinciding with the injection.
        do_eret();
        repeat (4) tick();
        supervise = 1'b1;
        irq_rise();
        repeat (3) tick();
        check("sup_pend", irq_pending, 1);
        check("sup_hold", IRQ, 0);
        ext_irq = 1'b0;
        repeat (2) tick();
        ext_irq = 1'b1;
        tick();
        check("sup_hold2", IRQ, 0);
        tick();                                   // edge detect high this cycle
        supervise = 1'b0;
        #1;
        check("sim_irq", IRQ, 1);
        tick();
        check("sim_pend_kept", irq_pending, 1);
        check("sim_count", irq_count, 4);
        check("sim_busy", irq_busy, 1);

        // Disabling clears the latch; disabled edges are discarded.
        irq_enable = 1'b0;
        tick();
        check("dis_clr", irq_pending, 0);
        do_eret();
        repeat (4) tick();
        check("dis_idle", irq_busy, 0);
        irq_rise();
        repeat (4) tick();
        check("dis_pend", irq_pending, 0);
        irq_enable = 1'b1;
        repeat (2) tick();
        check("dis_irq", IRQ, 0);
        check("dis_pend2", irq_pending, 0);
        check("dis_count", irq_count, 4);

        // Reset during service with count=5.
        irq_rise();
        repeat (3) tick();
        check("rs_irq", IRQ, 1);
        tick();
        check("rs_count", irq_count, 5);
        check("rs_busy", irq_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_irq0", IRQ, 0);
        check("rs_pend0", irq_pending, 0);
        check("rs_busy0", irq_busy, 0);
        check("rs_count0", irq_count, 0);
        ext_irq = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rs_after_busy", irq_busy, 0);
        check("rs_after_count", irq_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
